// File: rtl/r2r_dac_pkg.sv
// Shared types and helpers for the R2R DAC sample player.
package r2r_dac_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRIMING = 2'd1,
      PLAYING = 2'd2
   } state_t;

   // Occupancy needs one extra bit so that a completely full FIFO is representable.
   function automatic int fill_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Mid-rail ladder code, used as the idle/reset output level.
   function automatic logic [31:0] midscale(input int d_w);
      return 32'd1 << (d_w - 1);
   endfunction

endpackage

// File: rtl/r2r_dac_player_fifo.sv
// Show-ahead synchronous FIFO; pointers carry a wrap bit so full/empty fall out of a compare.
module sync_fifo
   import r2r_dac_pkg::*;
#(
   parameter int D_W   = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [D_W-1:0]         wdata,
   output logic [D_W-1:0]         rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = fill_w(DEPTH);

   logic [AW:0]    wptr, rptr;
   logic [D_W-1:0] mem [DEPTH];
   logic           do_push, do_pop;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A push into a full FIFO still lands if the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign count   = FW'(wptr - rptr);
   assign rdata   = mem[rptr[AW-1:0]];

   // Pointer advance; reset discards contents by collapsing both pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage array, no reset needed since occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/r2r_dac_player.sv
// Buffers deserializer words and replays them onto the R2R ladder at a programmable rate.
module r2r_dac_player
   import r2r_dac_pkg::*;
#(
   parameter int D_W   = 8,
   parameter int DEPTH = 8,
   parameter int PRIME = 4,
   parameter int DIV_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [D_W-1:0]         in_data,
   input  logic                   in_valid,
   input  logic                   enable,
   input  logic [DIV_W-1:0]       rate_div,
   input  logic                   clr_flags,
   output logic [D_W-1:0]         dac_out,
   output logic [$clog2(DEPTH):0] fill,
   output logic                   playing,
   output logic                   underrun,
   output logic                   overflow
);
   localparam int             FW      = fill_w(DEPTH);
   localparam logic [D_W-1:0] MID     = D_W'(midscale(D_W));
   localparam logic [FW-1:0]  PRIME_F = FW'(PRIME);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic             tick, pop, full, empty, ur_set, ov_set;
   logic [D_W-1:0]   head;

   sync_fifo #(.D_W(D_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (pop),
      .wdata (in_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fill)
   );

   // ">=" rather than "==" so shrinking rate_div below cnt ticks at once instead of wrapping.
   assign tick    = (cnt >= rate_div);
   assign pop     = enable && (state == PLAYING) && tick && !empty;
   assign ur_set  = enable && (state == PLAYING) && tick && empty;
   assign ov_set  = in_valid && full && !pop;
   assign playing = (state == PLAYING);

   // Playback FSM and sample-rate divider; the divider restarts on every entry to PLAYING.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (!enable) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE:    state <= PRIMING;
            PRIMING: if (fill >= PRIME_F) begin
                        state <= PLAYING;
                        cnt   <= '0;
                     end
            PLAYING: if (tick) begin
                        cnt <= '0;
                        if (empty) state <= PRIMING;
                     end else begin
                        cnt <= cnt + DIV_W'(1);
                     end
            default: state <= IDLE;
         endcase
      end
   end

   // Ladder code register: only a pop or reset moves it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   dac_out <= MID;
      else if (pop) dac_out <= head;
   end

   // Sticky error flags; a set event in the same cycle beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (ur_set)         underrun <= 1'b1;
         else if (clr_flags) underrun <= 1'b0;
         if (ov_set)         overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
      end
   end

endmodule
